dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU's data port (daddr/dwdata/dwe/drdata), plus a req/ready handshake so the memory side can insert wait states.
- Holds a word-organised RAM with byte-lane writes and a small MMIO window: free-running cycle counter, done flag, scratch register.
- Decodes every access and flags out-of-range addresses.
- Exactly one transaction is outstanding at a time.

Parameters:
- DEPTH, 1024: RAM size in 32-bit words; RAM occupies byte addresses 0 .. DEPTH*4-1.
- READ_LAT, 2: cycles from the accepting edge to the ready pulse for reads; legal range 1..15.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window; bits [3:0] are ignored.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req  in  1  request; held by requester until ready
- daddr  in  32  byte address
- dwdata  in  32  write data, lane-aligned
- dwe  in  4  byte-lane write enables; 0000 = read
- drdata  out  32  read data, registered
- ready  out  1  one-cycle completion pulse
- err  out  1  address-error pulse, coincident with ready
- done_flag  out  1  MMIO done bit

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE; ready=0, err=0, drdata=0, done_flag=0.
  - cycle counter=0, scratch=0, latency counter=0.
  - RAM contents are NOT reset.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - req=1 at a rising edge accepts the transaction: daddr, dwdata and dwe are captured. This edge is the accepting edge.
  - Write (dwe!=0): commits at the accepting edge, then goes to RESP.
  - Read, READ_LAT=1: read data is captured into drdata at the accepting edge, then goes to RESP.
  - Read, READ_LAT>1: read data is sampled at the accepting edge into a holding register, the latency counter is loaded with READ_LAT-1, then goes to BUSY.
- BUSY: the counter decrements each cycle. When it reaches 1, the next edge loads drdata from the holding register and enters RESP.
- RESP:
  - ready=1 (and err if flagged) for exactly one cycle, then IDLE. req is ignored while in RESP.
  - The earliest next accept is the edge after RESP.
  - Throughput: write = 2 cycles per access; read = READ_LAT+1 cycles per access.
- drdata holds its last read value until the next read response. Writes do not change drdata.
- Decode:
  - RAM when daddr < DEPTH*4; word index = daddr >> 2; daddr[1:0] is ignored.
  - MMIO when daddr[31:4] == MMIO_BASE[31:4].
  - Anything else is out of range.
- RAM write: only lanes with dwe[i]=1 update byte i. Any dwe pattern is legal.
- MMIO offsets (daddr[3:2]):
  - 0: CYCLE. Read-only, increments every clock, wraps from FFFF_FFFF to 0. A read returns the value at the accepting edge. Writes are ignored with no error.
  - 1: DONE. A write with dwe[0]=1 sets done_flag=dwdata[0], visible the cycle after the accepting edge. A read returns {31'b0, done_flag}.
  - 2: SCRATCH. 32-bit read/write with byte enables.
  - 3: reads 0; writes ignored; no error.
- Out of range:
  - Write is dropped.
  - Read returns drdata=0.
  - err=1 during the RESP cycle.
  - Timing is identical to an in-range access.
- req deasserted during BUSY: the transaction still completes and ready still pulses. No protocol checking is done.
- Reset asserted in BUSY or RESP:
  - The in-flight read is dropped; no ready pulse follows reset release.
  - A write committed at its accepting edge stays in RAM.
- Counter widths: latency counter is 4 bits; CYCLE is 32 bits, unsigned, and wraps.

Test Plan:
1. READ_LAT=2. Write 0xDEADBEEF to 0x10 with dwe=1111: ready pulses 1 cycle after accept. Read 0x10: ready pulses 2 cycles after accept with drdata=0xDEADBEEF.
2. Write dwe=0010, dwdata=0x0000AB00 to 0x10, then read 0x10: drdata=0xDEADABEF. Writes with dwe=1000 and dwe=0011 update only their lanes.
3. Read at DEPTH*4: err=1 and ready=1 in the same cycle, drdata=0. Write 0x12345678 there: err pulses. A RAM read at 0x0 is unchanged.
4. Write 1 to MMIO_BASE+4: done_flag=1 the next cycle; a read returns 0x1. Write 0: done_flag=0. SCRATCH write 0xA5A5A5A5 reads back 0xA5A5A5A5.
5. Two CYCLE reads whose accepting edges are 7 cycles apart: values differ by exactly 7. Force the counter near FFFF_FFFF and confirm it wraps to 0.
6. READ_LAT=4: reset asserted 2 cycles into BUSY drives ready, err, drdata and done_flag to 0 asynchronously. No ready pulse follows release. RAM still holds 0xDEADABEF at 0x10.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-port target with word RAM, byte lanes, MMIO window and req/ready wait states
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          READ_LAT  = 2,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        ready,
  output logic        err,
  output logic        done_flag
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_INIT  = 4'(READ_LAT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t          state, state_nx;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     cycle_cnt, scratch, hold, rd_val;
  logic [3:0]      lat_cnt;
  logic            err_q, in_ram, in_mmio, accept, is_wr, mmio_wr;
  logic [1:0]      off;
  logic [AW-1:0]   widx;
  assign in_ram  = {1'b0, daddr} < RAM_BYTES;
  assign in_mmio = daddr[31:4] == MMIO_BASE[31:4];
  assign off     = daddr[3:2];
  assign widx    = daddr[AW+1:2];
  assign is_wr   = |dwe;
  assign accept  = state == IDLE && req;
  assign mmio_wr = accept && !in_ram && in_mmio;
  assign ready   = state == RESP;
  assign err     = ready && err_q;
  // read value as seen at the accepting edge; out-of-range decodes to zero
  always_comb begin
    rd_val = in_ram ? mem[widx] :
             !in_mmio ? 32'd0 :
             off == 2'd0 ? cycle_cnt :
             off == 2'd1 ? {31'd0, done_flag} :
             off == 2'd2 ? scratch : 32'd0;
  end
  // next state: writes and single-cycle reads go straight to RESP, longer reads wait in BUSY
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req ? ((is_wr || READ_LAT == 1) ? RESP : BUSY) : IDLE) :
               state == BUSY ? (lat_cnt == 4'd1 ? RESP : BUSY) : IDLE;
  end
  // state, latency countdown, error flag and read-data pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      err_q   <= 1'b0;
      drdata  <= 32'd0;
      hold    <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        err_q   <= !(in_ram || in_mmio);
        lat_cnt <= LAT_INIT;
        hold    <= rd_val;
        if (!is_wr && READ_LAT == 1) drdata <= rd_val;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) drdata <= hold;
      end
    end
  end
  // free-running cycle counter and MMIO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      scratch   <= 32'd0;
      done_flag <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mmio_wr && off == 2'd1 && dwe[0]) done_flag <= dwdata[0];
      for (int i = 0; i < 4; i++)
        if (mmio_wr && off == 2'd2 && dwe[i]) scratch[8*i +: 8] <= dwdata[8*i +: 8];
    end
  end
  // RAM byte-lane writes commit at the accepting edge; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (accept && in_ram && dwe[i]) mem[widx][8*i +: 8] <= dwdata[8*i +: 8];
  end
endmodule
